// File: rtl/intc_sched_if.sv
// +----------------------------------------------------------------------+
// | Module      : intc_sched_if                                          |
// | Description : Bundle of peripheral events, CPU handshake and status  |
// |               signals of the interrupt sequencer.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

interface intc_sched_if #(
   parameter int N_SRC = 4
);
   logic [N_SRC-1:0] done;
   logic             mask_we;
   logic [N_SRC-1:0] mask_wdata;
   logic             lost_clr;
   logic             iack;
   logic             eoi;
   logic             irq;
   logic [31:0]      PC_handler;
   logic [2:0]       irq_id;
   logic             busy;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] lost;

   // Event sources and CPU side
   modport master (
      output done, mask_we, mask_wdata, lost_clr, iack, eoi,
      input  irq, PC_handler, irq_id, busy, pending, lost
   );

   // Sequencer side
   modport slave (
      input  done, mask_we, mask_wdata, lost_clr, iack, eoi,
      output irq, PC_handler, irq_id, busy, pending, lost
   );
endinterface

`default_nettype wire

// File: rtl/intc_sched.sv
// +----------------------------------------------------------------------+
// | Module      : intc_sched                                             |
// | Description : Interrupt sequencer. Latches rising edges of the done  |
// |               lines into pending bits, arbitrates among unmasked     |
// |               sources and runs a request / acknowledge / end-of-     |
// |               interrupt sequence towards the CPU.                    |
// |               Optional macro INTC_SCHED_RR_EN selects round-robin    |
// |               arbitration instead of fixed lowest-index priority.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module intc_sched #(
   parameter int          N_SRC          = 4,
   parameter logic [31:0] HANDLER_BASE   = 32'h0000_0100,
   parameter logic [31:0] HANDLER_STRIDE = 32'h0000_0010
) (
   input  wire logic      clk,
   input  wire logic      rst,
   intc_sched_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [N_SRC-1:0] r_done_q;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_lost;
   logic [N_SRC-1:0] r_mask;
   logic [2:0]       r_sel;
   logic [2:0]       r_irq_id;
   logic [31:0]      r_pc;
   logic             r_busy;

   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] w_clr;
   logic [N_SRC-1:0] w_sel_oh;
   logic [N_SRC-1:0] w_eligible;
   logic [N_SRC-1:0] w_lost_set;
   logic [2:0]       w_winner;
   logic             w_load;
   logic             w_ack;
   logic             w_sel_masked;

   assign w_rise       = bus.done & ~r_done_q;
   assign w_eligible   = r_pending & ~r_mask;
   assign w_sel_masked = |(r_mask & w_sel_oh);
   assign w_lost_set   = w_rise & r_pending & ~w_clr;

   // One-hot decode of the selected source and the pending bit an iack clears
   always_comb begin
      w_sel_oh = '0;
      w_clr    = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_sel_oh[i] = (r_sel == 3'(i));
         w_clr[i]    = w_ack && (r_sel == 3'(i));
      end
   end

`ifdef INTC_SCHED_RR_EN
   logic [2:0] r_ptr;
   logic [2:0] w_hi;
   logic [2:0] w_lo;
   logic       w_hi_any;

   // Cyclic search: first eligible at/after the pointer, else lowest overall
   always_comb begin
      w_hi     = '0;
      w_lo     = '0;
      w_hi_any = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_lo = 3'(i);
            if (3'(i) >= r_ptr) begin
               w_hi     = 3'(i);
               w_hi_any = 1'b1;
            end
         end
      end
      w_winner = w_hi_any ? w_hi : w_lo;
   end

   // Search pointer moves past the source that was just acknowledged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_ack) begin
         r_ptr <= (r_sel == 3'(N_SRC - 1)) ? 3'd0 : r_sel + 3'd1;
      end
   end
`else
   // Fixed priority: lowest eligible index wins
   always_comb begin
      w_winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_winner = 3'(i);
         end
      end
   end
`endif

   // Sequencer next state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ack       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_eligible) begin
               w_load      = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.iack) begin
               w_ack       = 1'b1;
               w_state_nxt = S_SERVICE;
            end else if (w_sel_masked) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SERVICE: begin
            if (bus.eoi) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, selection and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_irq_id <= '0;
         r_pc     <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_SERVICE);
         if (w_load) begin
            r_sel    <= w_winner;
            r_irq_id <= w_winner;
            r_pc     <= HANDLER_BASE + HANDLER_STRIDE * {29'd0, w_winner};
         end
      end
   end

   // Event capture: edge detect, pending, lost and mask registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done_q  <= '0;
         r_pending <= '0;
         r_lost    <= '0;
         r_mask    <= '0;
      end else begin
         r_done_q  <= bus.done;
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_lost    <= bus.lost_clr ? w_lost_set : (r_lost | w_lost_set);
         if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
         end
      end
   end

   assign bus.irq        = (r_state == S_REQ);
   assign bus.PC_handler = r_pc;
   assign bus.irq_id     = r_irq_id;
   assign bus.busy       = r_busy;
   assign bus.pending    = r_pending;
   assign bus.lost       = r_lost;

endmodule

`default_nettype wire
